// File: rtl/shift_arbiter.sv
// Arbiter/sequencer for the shared 32-bit shifter: grants one of two requesters, drives the
// external shifter from registered operands and returns the registered result. Optional: SHIFT_ARB_RR_EN.
module shift_arbiter #(
    parameter int unsigned W   = 32,
    parameter int unsigned SAW = 5
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_Req0Valid,
    output logic           o_Req0Ready,
    input  logic [1:0]     i_Req0Op,
    input  logic [SAW-1:0] i_Req0SA,
    input  logic [W-1:0]   i_Req0B,
    input  logic           i_Req1Valid,
    output logic           o_Req1Ready,
    input  logic [1:0]     i_Req1Op,
    input  logic [SAW-1:0] i_Req1SA,
    input  logic [W-1:0]   i_Req1B,
    output logic [1:0]     o_ShOp,
    output logic [SAW-1:0] o_ShSA,
    output logic [W-1:0]   o_ShB,
    input  logic [W-1:0]   i_ShRes,
    output logic           o_RspValid,
    input  logic           i_RspReady,
    output logic           o_RspId,
    output logic [W-1:0]   o_RspData,
    output logic           o_Busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [1:0]     op_q, op_d;
    logic [SAW-1:0] sa_q, sa_d;
    logic [W-1:0]   b_q, b_d;
    logic           id_q, id_d;
    logic [W-1:0]   rsp_data_q, rsp_data_d;
    logic           rsp_id_q, rsp_id_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic           busy_q, busy_d;
    logic           grant0, grant1;

`ifdef SHIFT_ARB_RR_EN
    // Pointer names the preferred port; it flips to the loser after every accept.
    logic ptr_q, ptr_d;

    always_comb begin
        grant0 = i_Req0Valid & (~i_Req1Valid | ~ptr_q);
        grant1 = i_Req1Valid & (~i_Req0Valid |  ptr_q);
        ptr_d  = ptr_q;
        if (state_q == ST_IDLE && (grant0 || grant1)) begin
            ptr_d = ~grant1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin
        grant0 = i_Req0Valid;
        grant1 = i_Req1Valid & ~i_Req0Valid;
    end
`endif

    // Next-state, operand capture and request readies.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        sa_d        = sa_q;
        b_d         = b_q;
        id_d        = id_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        o_Req0Ready = 1'b0;
        o_Req1Ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                o_Req0Ready = grant0;
                o_Req1Ready = grant1;
                if (grant1) begin
                    op_d    = i_Req1Op;
                    sa_d    = i_Req1SA;
                    b_d     = i_Req1B;
                    id_d    = 1'b1;
                    state_d = ST_EXEC;
                end else if (grant0) begin
                    op_d    = i_Req0Op;
                    sa_d    = i_Req0SA;
                    b_d     = i_Req0B;
                    id_d    = 1'b0;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_data_d = i_ShRes;
                rsp_id_d   = id_q;
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                if (i_RspReady) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        rsp_valid_d = (state_d == ST_RESP);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= 2'd0;
            sa_q        <= SAW'(0);
            b_q         <= W'(0);
            id_q        <= 1'b0;
            rsp_data_q  <= W'(0);
            rsp_id_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            sa_q        <= sa_d;
            b_q         <= b_d;
            id_q        <= id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign o_ShOp     = op_q;
    assign o_ShSA     = sa_q;
    assign o_ShB      = b_q;
    assign o_RspValid = rsp_valid_q;
    assign o_RspId    = rsp_id_q;
    assign o_RspData  = rsp_data_q;
    assign o_Busy     = busy_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter with a behavioural shifter attached to the o_Sh* outputs.
module tb_shift_arbiter;

    logic        clk;
    logic        rst_n;
    logic        v0, v1, r0, r1;
    logic [1:0]  op0, op1, sh_op;
    logic [4:0]  sa0, sa1, sh_sa;
    logic [31:0] b0, b1, sh_b, sh_res;
    logic [63:0] rot;
    logic        rsp_valid, rsp_ready, rsp_id, busy;
    logic [31:0] rsp_data;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        port;
        logic [1:0]  op;
        logic [4:0]  sa;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[7];

    shift_arbiter #(.W(32), .SAW(5)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_Req0Valid(v0), .o_Req0Ready(r0), .i_Req0Op(op0), .i_Req0SA(sa0), .i_Req0B(b0),
        .i_Req1Valid(v1), .o_Req1Ready(r1), .i_Req1Op(op1), .i_Req1SA(sa1), .i_Req1B(b1),
        .o_ShOp(sh_op), .o_ShSA(sh_sa), .o_ShB(sh_b), .i_ShRes(sh_res),
        .o_RspValid(rsp_valid), .i_RspReady(rsp_ready), .o_RspId(rsp_id),
        .o_RspData(rsp_data), .o_Busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference shifter: 0 SLL, 1 SRL, 2 SRA, 3 rotate-left.
    always_comb begin
        rot    = {sh_b, sh_b} << sh_sa;
        sh_res = 32'd0;
        case (sh_op)
            2'd0:    sh_res = sh_b << sh_sa;
            2'd1:    sh_res = sh_b >> sh_sa;
            2'd2:    sh_res = $unsigned($signed(sh_b) >>> sh_sa);
            default: sh_res = rot[63:32];
        endcase
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic port, input logic valid, input vec_t v);
        if (port) begin
            v1 = valid; op1 = v.op; sa1 = v.sa; b1 = v.b;
        end else begin
            v0 = valid; op0 = v.op; sa0 = v.sa; b0 = v.b;
        end
    endtask

    // One complete transaction with the consumer always ready.
    task automatic run_vec(input vec_t v);
        int n;
        logic rdy;
        @(negedge clk);
        rsp_ready = 1'b1;
        drive(v.port, 1'b1, v);
        n   = 0;
        rdy = v.port ? r1 : r0;
        while (!rdy && n < 8) begin
            @(negedge clk);
            n++;
            rdy = v.port ? r1 : r0;
        end
        chk("req_ready", {r1, r0}, v.port ? 64'd2 : 64'd1);
        @(posedge clk); #1;
        drive(v.port, 1'b0, v);
        chk("exec_busy_valid", {busy, rsp_valid}, 64'd2);
        chk("exec_sh_bus", {sh_op, sh_sa, sh_b}, {v.op, v.sa, v.b});
        @(posedge clk); #1;
        chk("rsp_valid", {busy, rsp_valid}, 64'd3);
        chk("rsp_data", rsp_data, v.exp);
        chk("rsp_id", rsp_id, v.port);
        @(posedge clk); #1;
        chk("back_idle", {busy, rsp_valid}, 64'd0);
    endtask

    initial begin
        vec_t  cv0, cv1, bp;
        int    ids[4];
        int    cyc[4];
        int    n, cnt, both_hi, r1_hi;
        logic  seen;
        logic [31:0] d_hold;

        vecs[0] = '{port: 1'b0, op: 2'd0, sa: 5'd4,  b: 32'h0000000F, exp: 32'h000000F0};
        vecs[1] = '{port: 1'b1, op: 2'd1, sa: 5'd1,  b: 32'h80000001, exp: 32'h40000000};
        vecs[2] = '{port: 1'b1, op: 2'd2, sa: 5'd1,  b: 32'h80000001, exp: 32'hC0000000};
        vecs[3] = '{port: 1'b1, op: 2'd3, sa: 5'd1,  b: 32'h80000001, exp: 32'h00000003};
        vecs[4] = '{port: 1'b0, op: 2'd3, sa: 5'd0,  b: 32'h12345678, exp: 32'h12345678};
        vecs[5] = '{port: 1'b1, op: 2'd0, sa: 5'd31, b: 32'h00000001, exp: 32'h80000000};
        vecs[6] = '{port: 1'b0, op: 2'd2, sa: 5'd31, b: 32'h80000000, exp: 32'hFFFFFFFF};

        rst_n = 1'b0; rsp_ready = 1'b0;
        v0 = 0; v1 = 0; op0 = 0; op1 = 0; sa0 = 0; sa1 = 0; b0 = 0; b1 = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {r0, r1, sh_op, sh_sa, sh_b, rsp_valid, rsp_id, busy}, 64'd0);
        chk("reset_rsp_data", rsp_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i]);
        end

        // Contention: both ports valid continuously from a fresh reset.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cv0 = '{port: 1'b0, op: 2'd0, sa: 5'd1, b: 32'h00000011, exp: 32'h00000022};
        cv1 = '{port: 1'b1, op: 2'd0, sa: 5'd1, b: 32'h00000100, exp: 32'h00000200};
        rsp_ready = 1'b1;
        drive(1'b0, 1'b1, cv0);
        drive(1'b1, 1'b1, cv1);
        cnt = 0; both_hi = 0; r1_hi = 0; n = 0;
        while (cnt < 4 && n < 60) begin
            @(negedge clk);
            n++;
            if (r0 && r1) both_hi++;
            if (r1) r1_hi++;
            if (rsp_valid) begin
                ids[cnt] = int'(rsp_id);
                cyc[cnt] = n;
                chk("cont_data", rsp_data, rsp_id ? cv1.exp : cv0.exp);
                cnt++;
            end
        end
        drive(1'b0, 1'b0, cv0);
        drive(1'b1, 1'b0, cv1);
        chk("cont_count", 64'(cnt), 64'd4);
        chk("cont_one_ready", 64'(both_hi), 64'd0);
        for (int i = 1; i < cnt; i++) begin
            chk("cont_issue_gap", 64'(cyc[i] - cyc[i-1]), 64'd3);
        end
`ifdef SHIFT_ARB_RR_EN
        chk("cont_order", {32'(ids[0]), 32'(ids[1]) << 1, 32'(ids[2]) << 2, 32'(ids[3]) << 3} != 0 ?
            64'({ids[3][0], ids[2][0], ids[1][0], ids[0][0]}) : 64'hF, 64'b1010);
`else
        chk("cont_order", 64'({ids[3][0], ids[2][0], ids[1][0], ids[0][0]}), 64'b0000);
        chk("cont_starve", 64'(r1_hi), 64'd0);
`endif
        // Drain any pending state back to IDLE.
        repeat (3) @(negedge clk);
        chk("cont_idle", {busy, rsp_valid}, 64'd0);

        // Back-pressure: response held for 10 cycles, late requester waits.
        bp = '{port: 1'b0, op: 2'd0, sa: 5'd8, b: 32'h000000AB, exp: 32'h0000AB00};
        @(negedge clk);
        rsp_ready = 1'b0;
        drive(1'b0, 1'b1, bp);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, bp);
        drive(1'b1, 1'b1, vecs[5]);
        @(posedge clk); #1;
        d_hold = rsp_data;
        chk("bp_data", d_hold, bp.exp);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_hold", {r0, r1, rsp_valid, rsp_id, rsp_data}, {4'b0010, bp.exp});
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_idle", {busy, rsp_valid, r1}, 64'b001);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, vecs[5]);
        @(posedge clk); #1;
        chk("bp_late_rsp", {rsp_valid, rsp_id, rsp_data}, {2'b11, vecs[5].exp});
        @(posedge clk); #1;

        // Asynchronous reset during EXEC discards the in-flight request.
        @(negedge clk);
        drive(1'b0, 1'b1, vecs[0]);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, vecs[0]);
        chk("rst_pre_busy", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_outputs", {r0, r1, sh_op, sh_sa, sh_b, rsp_valid, rsp_id, busy}, 64'd0);
        chk("rst_async_data", rsp_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid || busy) seen = 1'b1;
        end
        chk("rst_no_response", seen, 1'b0);
        run_vec('{port: 1'b1, op: 2'd0, sa: 5'd2, b: 32'h00000005, exp: 32'h00000014});

        // Idle hygiene: shifter bus holds the last operands with no activity.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_hygiene", {r0, r1, busy, sh_op, sh_sa, sh_b}, {3'b000, 2'd0, 5'd2, 32'h00000005});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
